// File: rtl/io_switch_conditioner_pkg.sv
// Package: io_switch_conditioner_pkg
// Purpose: Shared definitions for the switch conditioner. It holds the per-channel
//          debounce FSM state encoding (2-bit) and the default parameter values.
// Ports:   none (package)
package io_switch_conditioner_pkg;

  // Debounce FSM states. The two CHK states are the only states in which the
  // channel counter is nonzero.
  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'b00,
    ST_CHK_HI    = 2'b01,
    ST_STABLE_HI = 2'b10,
    ST_CHK_LO    = 2'b11
  } deb_state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_CNT_WIDTH       = 16;

endpackage

// File: rtl/io_switch_conditioner_if.sv
// Interface: io_switch_conditioner_if
// Purpose: Bundles the raw switch inputs, the processor clear strobes and the
//          conditioned outputs that go to the data-memory IO port.
// Signals:
//   raw_sw0, raw_sw1 : unsynchronised switch pins
//   clear_press[1:0] : per-channel strobe clearing press_pending (bit0 = sw0)
//   io_sw0, io_sw1   : debounced stable levels
//   sw_rise[1:0]     : one-cycle pulse on debounced 0->1
//   press_pending    : sticky press flags
//   settling[1:0]    : channel is currently qualifying a level change
// Modports:
//   master : environment side (drives pins and strobes, observes outputs)
//   slave  : conditioner side
interface io_switch_conditioner_if;
  logic       raw_sw0;
  logic       raw_sw1;
  logic [1:0] clear_press;
  logic       io_sw0;
  logic       io_sw1;
  logic [1:0] sw_rise;
  logic [1:0] press_pending;
  logic [1:0] settling;

  modport master (
    output raw_sw0, raw_sw1, clear_press,
    input  io_sw0, io_sw1, sw_rise, press_pending, settling
  );

  modport slave (
    input  raw_sw0, raw_sw1, clear_press,
    output io_sw0, io_sw1, sw_rise, press_pending, settling
  );
endinterface

// File: rtl/io_switch_conditioner_sw_debounce_chan.sv
// Module: io_switch_conditioner_sw_debounce_chan
// Purpose: One switch channel: synchroniser chain, 4-state debounce FSM with a
//          qualification counter, registered rise pulse, sticky press flag and
//          settling indicator. Every output is a flop; nothing is combinational
//          from an input.
// Ports:
//   clock      in  system clock
//   reset      in  asynchronous active-high reset
//   i_raw      in  raw switch pin
//   i_clear    in  clears o_pending (a simultaneous rise wins)
//   o_level    out debounced stable level
//   o_rise     out one-cycle pulse when o_level goes 0->1
//   o_pending  out sticky press flag
//   o_settling out high while in a CHK state
module io_switch_conditioner_sw_debounce_chan
  import io_switch_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  input  logic i_clear,
  output logic o_level,
  output logic o_rise,
  output logic o_pending,
  output logic o_settling
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  deb_state_t             r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_pending;
  logic                   r_settling;

  // Stage 0 samples the pin; the last stage is the only one the FSM may use.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // The counter holds the number of consecutive disagreeing samples seen so
  // far; a level flips on the sample after it reaches DEBOUNCE_CYCLES, so a
  // change must persist DEBOUNCE_CYCLES+1 samples to be accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_STABLE_LO;
      r_cnt      <= CNT_ZERO;
      r_level    <= 1'b0;
      r_rise     <= 1'b0;
      r_pending  <= 1'b0;
      r_settling <= 1'b0;
    end else begin
      r_rise    <= 1'b0;
      // Rise is OR-ed after the clear so a press coinciding with a clear is kept.
      r_pending <= r_rise | (r_pending & ~i_clear);
      case (r_state)
        ST_STABLE_LO: begin
          if (w_s) begin
            r_state    <= ST_CHK_HI;
            r_cnt      <= CNT_ONE;
            r_settling <= 1'b1;
          end else begin
            r_cnt      <= CNT_ZERO;
            r_settling <= 1'b0;
          end
        end
        ST_CHK_HI: begin
          if (!w_s) begin
            r_state    <= ST_STABLE_LO;
            r_cnt      <= CNT_ZERO;
            r_settling <= 1'b0;
          end else if (r_cnt == CNT_MAX) begin
            r_state    <= ST_STABLE_HI;
            r_cnt      <= CNT_ZERO;
            r_level    <= 1'b1;
            r_rise     <= 1'b1;
            r_settling <= 1'b0;
          end else begin
            r_cnt      <= r_cnt + CNT_ONE;
            r_settling <= 1'b1;
          end
        end
        ST_STABLE_HI: begin
          if (!w_s) begin
            r_state    <= ST_CHK_LO;
            r_cnt      <= CNT_ONE;
            r_settling <= 1'b1;
          end else begin
            r_cnt      <= CNT_ZERO;
            r_settling <= 1'b0;
          end
        end
        ST_CHK_LO: begin
          if (w_s) begin
            r_state    <= ST_STABLE_HI;
            r_cnt      <= CNT_ZERO;
            r_settling <= 1'b0;
          end else if (r_cnt == CNT_MAX) begin
            r_state    <= ST_STABLE_LO;
            r_cnt      <= CNT_ZERO;
            r_level    <= 1'b0;
            r_settling <= 1'b0;
          end else begin
            r_cnt      <= r_cnt + CNT_ONE;
            r_settling <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_STABLE_LO;
          r_cnt      <= CNT_ZERO;
          r_level    <= 1'b0;
          r_settling <= 1'b0;
        end
      endcase
    end
  end

  assign o_level    = r_level;
  assign o_rise     = r_rise;
  assign o_pending  = r_pending;
  assign o_settling = r_settling;

endmodule

// File: rtl/io_switch_conditioner.sv
// Module: io_switch_conditioner
// Purpose: Conditions the two raw board switches for the data-memory IO port.
//          Two independent debounce channels; bit0 of every vector is sw0,
//          bit1 is sw1.
// Ports:
//   clock : system clock, all state on rising edge
//   reset : asynchronous active-high reset
//   bus   : io_switch_conditioner_if.slave (pins, clear strobes, conditioned outputs)
module io_switch_conditioner
  import io_switch_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  io_switch_conditioner_if.slave    bus
);

  logic [1:0] w_raw;
  logic [1:0] w_level;
  logic [1:0] w_rise;
  logic [1:0] w_pending;
  logic [1:0] w_settling;

  assign w_raw = {bus.raw_sw1, bus.raw_sw0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      io_switch_conditioner_sw_debounce_chan #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
      ) u_chan (
        .clock      (clock),
        .reset      (reset),
        .i_raw      (w_raw[gi]),
        .i_clear    (bus.clear_press[gi]),
        .o_level    (w_level[gi]),
        .o_rise     (w_rise[gi]),
        .o_pending  (w_pending[gi]),
        .o_settling (w_settling[gi])
      );
    end
  endgenerate

  assign bus.io_sw0        = w_level[0];
  assign bus.io_sw1        = w_level[1];
  assign bus.sw_rise       = w_rise;
  assign bus.press_pending = w_pending;
  assign bus.settling      = w_settling;

endmodule

// File: tb/tb_io_switch_conditioner.sv
// Testbench: tb_io_switch_conditioner
// Purpose: Scenario tasks drive the switch pins; each expected debounced level
//          change (channel, value, clock edge) is pushed to a scoreboard queue
//          when the stimulus is applied and popped by a monitor when the DUT's
//          level actually changes. The monitor also requires sw_rise to be high
//          exactly on the cycles where a level went 0->1.
module tb_io_switch_conditioner;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    int   ch;
    logic val;
    int   cyc;
  } ev_t;

  ev_t exp_q[$];

  io_switch_conditioner_if bus();

  io_switch_conditioner dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // Scoreboard monitor
  logic [1:0] prev = 2'b00;
  always @(negedge clock) begin
    logic [1:0] cur;
    logic       exp_rise;
    int         idx;
    cur = {bus.io_sw1, bus.io_sw0};
    if (reset) begin
      prev = 2'b00;
    end else begin
      if (mon_en) begin
        for (int ch = 0; ch < 2; ch++) begin
          if (cur[ch] !== prev[ch]) begin
            checks++;
            idx = -1;
            for (int i = 0; i < exp_q.size(); i++) begin
              if (exp_q[i].ch == ch) begin
                idx = i;
                break;
              end
            end
            if (idx < 0) begin
              errors++;
              $display("FAIL level_change ch%0d: got unexpected change to %b at edge %0d, required no change",
                       ch, cur[ch], cyc);
            end else begin
              if (exp_q[idx].val !== cur[ch] || exp_q[idx].cyc != cyc) begin
                errors++;
                $display("FAIL level_change ch%0d: got value %b at edge %0d, required value %b at edge %0d",
                         ch, cur[ch], cyc, exp_q[idx].val, exp_q[idx].cyc);
              end else begin
                $display("level ch%0d -> %b at edge %0d", ch, cur[ch], cyc);
              end
              exp_q.delete(idx);
            end
          end
          exp_rise = cur[ch] & ~prev[ch];
          checks++;
          if (bus.sw_rise[ch] !== exp_rise) begin
            errors++;
            $display("FAIL sw_rise ch%0d: got %b at edge %0d, required %b", ch, bus.sw_rise[ch], cyc, exp_rise);
          end
        end
      end
      prev = cur;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: got %0d outstanding expected level changes, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    bus.raw_sw0     = 1'b0;
    bus.raw_sw1     = 1'b0;
    bus.clear_press = 2'b00;
    reset           = 1'b1;
    wait_neg(2);
    checks++;
    if ({bus.io_sw1, bus.io_sw0, bus.sw_rise, bus.press_pending, bus.settling} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: got io=%b%b rise=%b pend=%b settle=%b, required all 0",
               bus.io_sw1, bus.io_sw0, bus.sw_rise, bus.press_pending, bus.settling);
    end
    reset = 1'b0;
    // Qualify both channels so the async reset has real state to clear.
    bus.raw_sw0 = 1'b1;
    bus.raw_sw1 = 1'b1;
    wait_neg(10);
    checks++;
    if ({bus.io_sw1, bus.io_sw0, bus.press_pending} !== 4'b1111) begin
      errors++;
      $display("FAIL pre_reset_state: got io=%b%b pend=%b, required io=11 pend=11",
               bus.io_sw1, bus.io_sw0, bus.press_pending);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.io_sw1, bus.io_sw0, bus.sw_rise, bus.press_pending, bus.settling} !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got io=%b%b rise=%b pend=%b settle=%b before any edge, required all 0",
               bus.io_sw1, bus.io_sw0, bus.sw_rise, bus.press_pending, bus.settling);
    end
    bus.raw_sw0 = 1'b0;
    bus.raw_sw1 = 1'b0;
    wait_neg(2);
    reset = 1'b0;
    wait_neg(3);
    mon_en = 1'b1;
    $display("reset test done at edge %0d", cyc);
  endtask

  task automatic test_clean_press();
    int m;
    @(negedge clock);
    m = cyc;
    bus.raw_sw0 = 1'b1;
    exp_q.push_back('{ch: 0, val: 1'b1, cyc: m + 7});
    $display("press ch0 driven after edge %0d", m);
    for (int j = 1; j <= 9; j++) begin
      @(negedge clock);
      if (cyc == m + 3) begin
        checks++;
        if (bus.settling[0] !== 1'b1) begin
          errors++;
          $display("FAIL press_settling: got %b at edge %0d, required 1", bus.settling[0], cyc);
        end
      end
      if (cyc == m + 6) begin
        checks++;
        if (bus.io_sw0 !== 1'b0) begin
          errors++;
          $display("FAIL press_early: got io_sw0=%b at edge %0d, required 0", bus.io_sw0, cyc);
        end
      end
      if (cyc == m + 7) begin
        checks++;
        if (bus.io_sw0 !== 1'b1 || bus.sw_rise[0] !== 1'b1 || bus.settling[0] !== 1'b0) begin
          errors++;
          $display("FAIL press_edge: got io_sw0=%b rise=%b settle=%b, required 1 1 0",
                   bus.io_sw0, bus.sw_rise[0], bus.settling[0]);
        end
      end
      if (cyc >= m + 8) begin
        checks++;
        if (bus.press_pending[0] !== 1'b1 || bus.sw_rise[0] !== 1'b0) begin
          errors++;
          $display("FAIL press_pending: got pend=%b rise=%b at edge %0d, required 1 0",
                   bus.press_pending[0], bus.sw_rise[0], cyc);
        end
      end
    end
    check_queue_empty("press_queue");
  endtask

  // Hold one channel high for len sampled edges; accepted pulses also yield a
  // fall DEBOUNCE_CYCLES+SYNC_STAGES edges after the pin returns low.
  task automatic test_pulse(input int ch, input int len, input bit accept);
    int m;
    bit saw_settle;
    saw_settle = 1'b0;
    @(negedge clock);
    m = cyc;
    if (ch == 0) bus.raw_sw0 = 1'b1; else bus.raw_sw1 = 1'b1;
    if (accept) begin
      exp_q.push_back('{ch: ch, val: 1'b1, cyc: m + 7});
      exp_q.push_back('{ch: ch, val: 1'b0, cyc: m + 1 + len + 6});
    end
    $display("pulse ch%0d len %0d driven after edge %0d", ch, len, m);
    for (int j = 1; j <= len + 14; j++) begin
      @(negedge clock);
      if (j == len) begin
        if (ch == 0) bus.raw_sw0 = 1'b0; else bus.raw_sw1 = 1'b0;
      end
      if (bus.settling[ch] === 1'b1) saw_settle = 1'b1;
    end
    checks++;
    if (saw_settle !== 1'b1 || bus.settling[ch] !== 1'b0) begin
      errors++;
      $display("FAIL pulse_settling ch%0d len %0d: got seen=%b final=%b, required 1 0",
               ch, len, saw_settle, bus.settling[ch]);
    end
    checks++;
    if (bus.press_pending[ch] !== accept) begin
      errors++;
      $display("FAIL pulse_pending ch%0d len %0d: got %b, required %b", ch, len, bus.press_pending[ch], accept);
    end
    check_queue_empty("pulse_queue");
  endtask

  task automatic test_release();
    int m;
    @(negedge clock);
    m = cyc;
    bus.raw_sw0 = 1'b0;
    exp_q.push_back('{ch: 0, val: 1'b0, cyc: m + 7});
    $display("release ch0 driven after edge %0d", m);
    wait_neg(10);
    checks++;
    if (bus.io_sw0 !== 1'b0 || bus.press_pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL release: got io_sw0=%b pend=%b, required 0 1", bus.io_sw0, bus.press_pending[0]);
    end
    check_queue_empty("release_queue");
  endtask

  task automatic test_clear_race();
    int m;
    @(negedge clock);
    bus.clear_press = 2'b01;
    @(negedge clock);
    bus.clear_press = 2'b00;
    checks++;
    if (bus.press_pending !== 2'b10) begin
      errors++;
      $display("FAIL clear_basic: got pend=%b, required 10 (ch1 untouched)", bus.press_pending);
    end
    bus.clear_press = 2'b01;
    @(negedge clock);
    bus.clear_press = 2'b00;
    checks++;
    if (bus.press_pending !== 2'b10) begin
      errors++;
      $display("FAIL clear_noop: got pend=%b, required 10", bus.press_pending);
    end
    m = cyc;
    bus.raw_sw0 = 1'b1;
    exp_q.push_back('{ch: 0, val: 1'b1, cyc: m + 7});
    $display("clear race press ch0 driven after edge %0d", m);
    wait_neg(7);
    checks++;
    if (bus.sw_rise[0] !== 1'b1) begin
      errors++;
      $display("FAIL race_rise: got sw_rise0=%b at edge %0d, required 1", bus.sw_rise[0], cyc);
    end
    bus.clear_press = 2'b01;
    @(negedge clock);
    checks++;
    if (bus.press_pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL race_set_wins: got pend0=%b, required 1", bus.press_pending[0]);
    end
    @(negedge clock);
    bus.clear_press = 2'b00;
    checks++;
    if (bus.press_pending[0] !== 1'b0) begin
      errors++;
      $display("FAIL race_clear_later: got pend0=%b, required 0", bus.press_pending[0]);
    end
    check_queue_empty("race_queue");
  endtask

  task automatic test_reset_mid_count();
    int m;
    @(negedge clock);
    m = cyc;
    bus.raw_sw0 = 1'b0;
    exp_q.push_back('{ch: 0, val: 1'b0, cyc: m + 7});
    wait_neg(10);
    m = cyc;
    bus.raw_sw0 = 1'b1;
    wait_neg(4);
    checks++;
    if (bus.settling[0] !== 1'b1) begin
      errors++;
      $display("FAIL midcount_chk: got settling0=%b, required 1", bus.settling[0]);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.io_sw0 !== 1'b0 || bus.settling !== 2'b00 || bus.press_pending !== 2'b00) begin
      errors++;
      $display("FAIL midcount_reset: got io_sw0=%b settle=%b pend=%b, required 0 00 00",
               bus.io_sw0, bus.settling, bus.press_pending);
    end
    #1 reset = 1'b0;
    m = cyc;
    exp_q.push_back('{ch: 0, val: 1'b1, cyc: m + 7});
    $display("reset released mid-count after edge %0d", m);
    wait_neg(9);
    checks++;
    if (bus.io_sw0 !== 1'b1 || bus.press_pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL midcount_requalify: got io_sw0=%b pend0=%b, required 1 1", bus.io_sw0, bus.press_pending[0]);
    end
    check_queue_empty("midcount_queue");
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_pulse(1, 3, 1'b0);
    test_pulse(1, 4, 1'b0);
    test_pulse(1, 5, 1'b1);
    test_release();
    test_clear_race();
    test_reset_mid_count();
    wait_neg(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
